// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg
//   Shared types and helpers for the PWM update scheduler.
//   state_t   : scheduler FSM states
//   boot_hold : BOOT hold-off length for a given transducer count; the
//               margin covers a preconditioner run that was in flight when
//               the scheduler came out of reset.
package pwm_sched_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        CFG,
        LAUNCH,
        WAIT
    } state_t;

    localparam int BootMargin = 16;

    function automatic int boot_hold(input int depth);
        return depth + BootMargin;
    endfunction

endpackage

// File: rtl/pwm_sched_watchdog.sv
// pwm_sched_watchdog
//   Cycle counter shared by the BOOT hold-off and the WAIT timeout.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clear    : restart the count from zero (wins over enable)
//     enable   : count this cycle
//     limit    : terminal count; tc fires on the limit-th enabled cycle
//     tc       : combinational terminal-count pulse
module pwm_sched_watchdog #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic          tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // tc deliberately ignores clear: clear is derived from the next state,
    // which itself depends on tc.
    assign tc = enable && (count == limit - 1'b1);

endmodule

// File: rtl/pwm_update_scheduler.sv
// pwm_update_scheduler
//   Serialises duty/phase updates and CYCLE reconfiguration towards the PWM
//   preconditioner. DUTY_OUT/PHASE_OUT only move on the IDLE->LAUNCH step,
//   so they are stable for the whole preconditioner run.
//   Optional feature: define SCHED_STATS_EN to add STAT_COALESCED/STAT_RUNS.
//
//   state  | meaning
//   BOOT   | hold-off after reset/timeout, preconditioner may still be running
//   IDLE   | arbitrate: CYCLE change > pending update > rerun
//   CFG    | CYCLE write window, ACK pulsed on entry, wait for REQ to drop
//   LAUNCH | fire PRE_DIN_VALID
//   WAIT   | wait for PRE_DOUT_VALID, watchdog running
//
//   Ports:
//     CLK, RST             clock, asynchronous active-high reset
//     UPDATE_REQ           strobe, DUTY_IN/PHASE_IN valid
//     DUTY_IN, PHASE_IN    requested duty/phase
//     CYCLE_CHG_REQ        level request to change CYCLE
//     CYCLE_CHG_ACK        pulse, CYCLE may be written now
//     DUTY_OUT, PHASE_OUT  values presented to the preconditioner
//     PRE_DIN_VALID        launch strobe to the preconditioner
//     PRE_DOUT_VALID       completion pulse from the preconditioner
//     UPDATE_DONE          pulse, new RISE/FALL applied
//     BUSY                 high in every state except IDLE
//     ERR_TIMEOUT          sticky run timeout flag
//     STAT_COALESCED       (SCHED_STATS_EN) saturating coalesced-request count
//     STAT_RUNS            (SCHED_STATS_EN) saturating launch count
module pwm_update_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int WIDTH   = 13,
    parameter int DEPTH   = 249,
    parameter int TIMEOUT = 512
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UPDATE_REQ,
    input  logic [WIDTH-1:0] DUTY_IN,
    input  logic [WIDTH-1:0] PHASE_IN,
    input  logic             CYCLE_CHG_REQ,
    output logic             CYCLE_CHG_ACK,
    output logic [WIDTH-1:0] DUTY_OUT,
    output logic [WIDTH-1:0] PHASE_OUT,
    output logic             PRE_DIN_VALID,
    input  logic             PRE_DOUT_VALID,
    output logic             UPDATE_DONE,
    output logic             BUSY,
    output logic             ERR_TIMEOUT
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]      STAT_COALESCED,
    output logic [15:0]      STAT_RUNS
`endif
);

    localparam int BootHold = boot_hold(DEPTH);
    localparam int CntMax   = (TIMEOUT > BootHold) ? TIMEOUT : BootHold;
    localparam int CW       = $clog2(CntMax + 1) + 1;
    localparam logic [CW-1:0] TimeoutLim = CW'(TIMEOUT);
    localparam logic [CW-1:0] BootLim    = CW'(BootHold);

    state_t           state;
    state_t           state_nxt;
    logic             pend;
    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] pend_phase;
    logic             rerun;
    logic             launch_pend;
    logic             launch_rerun;
    logic             cfg_exit;
    logic             run_done;
    logic             timeout_hit;
    logic             wd_clear;
    logic             wd_enable;
    logic [CW-1:0]    wd_limit;
    logic             wd_tc;

    assign wd_enable = (state == BOOT) || (state == WAIT);
    assign wd_clear  = (state_nxt != state);
    assign wd_limit  = (state == WAIT) ? TimeoutLim : BootLim;

    pwm_sched_watchdog #(
        .CW(CW)
    ) u_wdog (
        .clk   (CLK),
        .rst   (RST),
        .clear (wd_clear),
        .enable(wd_enable),
        .limit (wd_limit),
        .tc    (wd_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        launch_pend  = 1'b0;
        launch_rerun = 1'b0;
        cfg_exit     = 1'b0;
        run_done     = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            BOOT: begin
                if (wd_tc) state_nxt = IDLE;
            end
            IDLE: begin
                if (CYCLE_CHG_REQ) begin
                    state_nxt = CFG;
                end else if (pend) begin
                    state_nxt   = LAUNCH;
                    launch_pend = 1'b1;
                end else if (rerun) begin
                    state_nxt    = LAUNCH;
                    launch_rerun = 1'b1;
                end
            end
            CFG: begin
                if (!CYCLE_CHG_REQ) begin
                    state_nxt = IDLE;
                    cfg_exit  = 1'b1;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion on the last allowed cycle still counts.
                if (PRE_DOUT_VALID) begin
                    state_nxt = IDLE;
                    run_done  = 1'b1;
                end else if (wd_tc) begin
                    state_nxt   = BOOT;
                    timeout_hit = 1'b1;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CYCLE_CHG_ACK <= 1'b0;
            DUTY_OUT      <= '0;
            PHASE_OUT     <= '0;
            PRE_DIN_VALID <= 1'b0;
            UPDATE_DONE   <= 1'b0;
            BUSY          <= 1'b0;
            ERR_TIMEOUT   <= 1'b0;
            pend          <= 1'b0;
            pend_duty     <= '0;
            pend_phase    <= '0;
            rerun         <= 1'b0;
        end else begin
            CYCLE_CHG_ACK <= (state == IDLE) && (state_nxt == CFG);
            PRE_DIN_VALID <= (state == LAUNCH);
            UPDATE_DONE   <= run_done;
            BUSY          <= (state_nxt != IDLE);
            if (timeout_hit) ERR_TIMEOUT <= 1'b1;

            if (launch_pend) begin
                DUTY_OUT  <= pend_duty;
                PHASE_OUT <= pend_phase;
            end

            // A request landing on the consume cycle survives as the next pend.
            if (UPDATE_REQ) begin
                pend       <= 1'b1;
                pend_duty  <= DUTY_IN;
                pend_phase <= PHASE_IN;
            end else if (launch_pend) begin
                pend <= 1'b0;
            end

            // A pend launch already recomputes with the new CYCLE, so it
            // absorbs any outstanding rerun.
            if (cfg_exit) begin
                rerun <= 1'b1;
            end else if (launch_pend || launch_rerun) begin
                rerun <= 1'b0;
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STAT_COALESCED <= '0;
            STAT_RUNS      <= '0;
        end else begin
            if (UPDATE_REQ && pend && (STAT_COALESCED != 16'hFFFF)) begin
                STAT_COALESCED <= STAT_COALESCED + 16'd1;
            end
            if (PRE_DIN_VALID && (STAT_RUNS != 16'hFFFF)) begin
                STAT_RUNS <= STAT_RUNS + 16'd1;
            end
        end
    end
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// tb_pwm_update_scheduler
//   Bench for pwm_update_scheduler with DEPTH=8, TIMEOUT=64. A small
//   responder stands in for the preconditioner and answers each launch ten
//   cycles later unless disconnected. Expected duty/phase pairs are queued
//   when an update is driven and checked at each PRE_DIN_VALID.
//   Honours SCHED_STATS_EN when the design is built with it.
module tb_pwm_update_scheduler;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         update_req = 1'b0;
    logic         cycle_chg_req = 1'b0;
    logic [W-1:0] duty_in = '0;
    logic [W-1:0] phase_in = '0;
    logic         resp_pulse = 1'b0;
    logic         stray_pulse = 1'b0;
    logic         connected = 1'b1;
    logic         pre_dout_valid;
    logic         cycle_chg_ack;
    logic [W-1:0] duty_out;
    logic [W-1:0] phase_out;
    logic         pre_din_valid;
    logic         update_done;
    logic         busy;
    logic         err_timeout;
`ifdef SCHED_STATS_EN
    logic [15:0]  stat_coalesced;
    logic [15:0]  stat_runs;
`endif

    assign pre_dout_valid = resp_pulse | stray_pulse;

    pwm_update_scheduler #(
        .WIDTH  (W),
        .DEPTH  (8),
        .TIMEOUT(64)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .UPDATE_REQ    (update_req),
        .DUTY_IN       (duty_in),
        .PHASE_IN      (phase_in),
        .CYCLE_CHG_REQ (cycle_chg_req),
        .CYCLE_CHG_ACK (cycle_chg_ack),
        .DUTY_OUT      (duty_out),
        .PHASE_OUT     (phase_out),
        .PRE_DIN_VALID (pre_din_valid),
        .PRE_DOUT_VALID(pre_dout_valid),
        .UPDATE_DONE   (update_done),
        .BUSY          (busy),
        .ERR_TIMEOUT   (err_timeout)
`ifdef SCHED_STATS_EN
        ,
        .STAT_COALESCED(stat_coalesced),
        .STAT_RUNS     (stat_runs)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int release_cyc = 0;
    int runs = 0;
    int dones = 0;
    int acks = 0;
    int first_launch_cyc = -1;
    int last_launch_cyc = -1;
    int last_done_cyc = -1;
    int last_ack_cyc = -1;
    int resp_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic           prev_busy = 1'b0;
    logic [W-1:0]   prev_duty = '0;
    logic [W-1:0]   prev_phase = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Preconditioner stand-in.
    always @(posedge clk) begin
        #1;
        resp_pulse = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && connected) resp_pulse = 1'b1;
        end
        if (pre_din_valid) resp_cnt = 10;
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (!rst) begin
            if (pre_din_valid) begin
                runs++;
                last_launch_cyc = cyc;
                if (first_launch_cyc < 0) first_launch_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("launch_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("launch_duty", duty_out, e[2*W-1:W]);
                    check_eq("launch_phase", phase_out, e[W-1:0]);
                end
            end
            if (update_done) begin
                dones++;
                last_done_cyc = cyc;
            end
            if (cycle_chg_ack) begin
                acks++;
                last_ack_cyc = cyc;
            end
            if (prev_busy && busy) begin
                check_eq("stable_duty", duty_out, prev_duty);
                check_eq("stable_phase", phase_out, prev_phase);
            end
            prev_busy  = busy;
            prev_duty  = duty_out;
            prev_phase = phase_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_update(input logic [W-1:0] d, input logic [W-1:0] p);
        duty_in    = d;
        phase_in   = p;
        update_req = 1'b1;
        tick(1);
        update_req = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic [W-1:0] p);
        exp_q.push_back({d, p});
    endtask

    task automatic wait_runs(input int target, input int bound, input string tag);
        for (int i = 0; i < bound && runs < target; i++) tick(1);
        check_eq(tag, runs >= target, 1);
    endtask

    task automatic wait_dones(input int target, input int bound, input string tag);
        for (int i = 0; i < bound && dones < target; i++) tick(1);
        check_eq(tag, dones >= target, 1);
    endtask

    initial begin
        int t0;
        int err_cyc;

        // Reset
        tick(3);
        check_eq("rst_duty", duty_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_din_valid", pre_din_valid, 0);
        tick(2);
        rst = 1'b0;
        release_cyc = cyc;

        // Boot hold-off with an early request
        tick(2);
        push_exp(100, 20);
        send_update(100, 20);
        check_eq("boot_busy", busy, 1);
        tick(20);
        check_eq("boot_no_early_launch", runs, 0);
        wait_runs(1, 50, "boot_launch_seen");
        check_eq("boot_launch_cyc", first_launch_cyc - release_cyc, 26);
        wait_dones(1, 50, "boot_done_seen");
        check_eq("boot_duty", duty_out, 100);

        // Idle latency
        tick(2);
        t0 = cyc;
        push_exp(50, 9);
        send_update(50, 9);
        wait_runs(2, 20, "lat_launch_seen");
        check_eq("lat_cycles", last_launch_cyc - t0, 3);
        wait_dones(2, 50, "lat_done_seen");

        // Coalescing during WAIT
        tick(2);
        push_exp(1, 1);
        send_update(1, 1);
        wait_runs(3, 20, "coal_first_launch");
        send_update(10, 0);
        send_update(20, 5);
        send_update(30, 7);
        push_exp(30, 7);
        wait_dones(4, 100, "coal_done_seen");
        tick(20);
        check_eq("coal_runs", runs, 4);
        check_eq("coal_dones", dones, 4);
        check_eq("coal_duty", duty_out, 30);
        check_eq("coal_phase", phase_out, 7);

        // Completion outside WAIT is ignored
        stray_pulse = 1'b1;
        tick(1);
        stray_pulse = 1'b0;
        tick(3);
        check_eq("stray_dout_ignored", dones, 4);

        // CYCLE change requested mid-run
        push_exp(40, 3);
        send_update(40, 3);
        wait_runs(5, 20, "cfg_run_launch");
        cycle_chg_req = 1'b1;
        for (int i = 0; i < 100 && acks < 1; i++) tick(1);
        check_eq("cfg_ack_seen", acks, 1);
        check_eq("cfg_done_before_ack", dones, 5);
        check_eq("cfg_ack_after_done", last_ack_cyc - last_done_cyc, 1);
        tick(3);
        check_eq("cfg_ack_single", acks, 1);
        check_eq("cfg_no_launch", runs, 5);
        push_exp(40, 3);
        cycle_chg_req = 1'b0;
        wait_dones(6, 100, "cfg_rerun_done");
        check_eq("cfg_rerun_runs", runs, 6);

        // CYCLE change and pend together in IDLE
        tick(2);
        duty_in       = 77;
        phase_in      = 11;
        update_req    = 1'b1;
        cycle_chg_req = 1'b1;
        push_exp(77, 11);
        tick(1);
        update_req = 1'b0;
        for (int i = 0; i < 20 && acks < 2; i++) tick(1);
        check_eq("prio_ack_seen", acks, 2);
        tick(2);
        check_eq("prio_cfg_first", runs, 6);
        cycle_chg_req = 1'b0;
        wait_dones(7, 100, "prio_done_seen");
        tick(30);
        check_eq("prio_single_run", runs, 7);
        check_eq("prio_launch_after_ack", last_launch_cyc > last_ack_cyc, 1);

        // Timeout, re-hold and recovery
        connected = 1'b0;
        push_exp(5, 5);
        send_update(5, 5);
        wait_runs(8, 20, "to_launch_seen");
        t0 = last_launch_cyc;
        for (int i = 0; i < 200 && !err_timeout; i++) tick(1);
        err_cyc = cyc;
        check_eq("to_err_set", err_timeout, 1);
        check_eq("to_err_cyc", err_cyc - t0, 64);
        tick(5);
        check_eq("to_busy_boot_a", busy, 1);
        push_exp(6, 6);
        send_update(6, 6);
        tick(5);
        check_eq("to_busy_boot_b", busy, 1);
        connected = 1'b1;
        wait_dones(8, 300, "to_recover_done");
        check_eq("to_err_sticky", err_timeout, 1);
        check_eq("to_recover_duty", duty_out, 6);
        tick(20);
        check_eq("total_runs", runs, 9);
        check_eq("queue_drained", exp_q.size(), 0);
`ifdef SCHED_STATS_EN
        check_eq("stat_coalesced", stat_coalesced, 2);
        check_eq("stat_runs", stat_runs, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
